fixed_div_iter: RTL and testbench
=================================

# fixed_div_iter

Parametrised iterative fixed-point divider with AXI-Stream operand and result channels. It computes a quotient with optional fractional bits plus a remainder, in signed or unsigned mode, one quotient bit per clock. It adds divide-by-zero and overflow flags and full output backpressure. It is the next generation of the fixed-point arithmetic library's divider, used wherever a variable-latency-tolerant, area-cheap divide is needed.

## Interface
- `SIGNED`, default 1: 1 means both operands and the results are two's complement; 0 means unsigned.
- `WIDTH_A`, default 16: dividend width.
- `WIDTH_B`, default 8: divisor width, and also the remainder width.
- `FRAC_BITS`, default 0: extra fractional quotient bits. QW = WIDTH_A + FRAC_BITS.
- `aclk` in 1: the only clock.
- `areset` in 1: asynchronous, active-high reset.
- `s_axis_a_tdata` in WIDTH_A: dividend.
- `s_axis_a_tvalid` in 1, `s_axis_a_tready` out 1.
- `s_axis_b_tdata` in WIDTH_B: divisor.
- `s_axis_b_tvalid` in 1, `s_axis_b_tready` out 1.
- `m_axis_tdata` out QW+WIDTH_B: [QW+WIDTH_B-1:WIDTH_B] holds the quotient; [WIDTH_B-1:0] holds the remainder.
- `m_axis_tuser` out 2: bit0 = dbz (divide by zero), bit1 = ovf (overflow).
- `m_axis_tvalid` out 1, `m_axis_tready` in 1.

## Operation
- States: IDLE, PREP, ITER, FIX, OUT.
- IDLE:
  - Both treadys are high, except while `areset` is asserted and on the first clock after it deasserts.
  - A joint transfer occurs when both tvalids are high in the same cycle.
  - If only one operand is valid, nothing is accepted. The valid operand waits; it is never captured alone.
- Capture edge (IDLE→PREP): register both operands.
- PREP:
  - Form |a| and |b|. Magnitudes are computed WIDTH+1 wide so that the minimum negative value is exact.
  - qsign = sa^sb; rsign = sa. In unsigned mode both signs are 0.
  - dbz = (b == 0).
  - Shift register = |a| followed by FRAC_BITS zeros. rem = 0. cnt = 0.
  - Go to ITER.
- ITER (restoring step, one per cycle):
  - rem' = {rem, shift MSB}. rem is WIDTH_B+1 bits wide.
  - If rem' >= |b|: subtract |b| and the quotient bit is 1. Otherwise the quotient bit is 0.
  - Shift the shift register and the quotient left by one.
  - Go to FIX when cnt == QW-1; otherwise cnt++.
- FIX:
  - Negate the quotient if qsign; negate the remainder if rsign. This gives truncation toward zero, with the remainder taking the sign of the dividend.
  - If dbz: quotient saturates. Unsigned gives all ones. Signed gives max positive when a >= 0 and min negative when a < 0. Remainder = 0.
  - ovf (signed only): set when the magnitude result equals 2^(QW-1) and qsign = 0. The quotient then saturates to max positive and the remainder is 0.
  - ovf is never set in unsigned mode.
- OUT:
  - m_axis_tvalid = 1. tdata and tuser are held stable until m_axis_tready.
  - On the handshake edge, go to IDLE.
- Reset (at any time, including mid-ITER or in OUT):
  - State goes to IDLE immediately.
  - m_axis_tvalid = 0, tdata = 0, tuser = 0, both treadys = 0.
  - The in-flight operation is discarded; no partial result is ever presented.

## Timing
- Latency: with the capture at edge k, m_axis_tvalid rises after edge k+QW+2.
- The dbz and ovf cases take the same latency as normal cases.
- Throughput with tready tied high: one result per QW+4 cycles (PREP + QW×ITER + FIX + OUT + IDLE).
- treadys are low in every state other than IDLE. They rise the cycle after the output handshake.
- m_axis_tvalid never drops without a handshake.
- m_axis_tready is ignored outside OUT.
- Outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `fixed_div_pkg`:
  - state enum.
  - TUSER_DBZ = 0 and TUSER_OVF = 1 index constants.
  - `qw(WIDTH_A, FRAC_BITS)` function.
- Sub-module `fixed_div_step`: combinational single restoring step. Inputs are rem, the incoming bit and |b|; outputs are the next rem and the quotient bit. It is instantiated once inside ITER.

## Test plan
- Unsigned (SIGNED=0, 16/8, F=0): a=100, b=7 → q=14, r=2, tuser=0. tvalid rises QW+2=18 cycles after capture.
- Signed, sign handling:
  - a=-100, b=7 → q=-14 (0xFFF2), r=-2 (0xFE).
  - a=100, b=-7 → q=-14, r=2.
- Fractional (SIGNED=0, F=8): a=1, b=3 → q=0x000055, r=1. Latency is 26 cycles.
- Divide by zero:
  - Signed: a=-5, b=0 → q=0x8000, r=0, dbz=1.
  - Signed: a=5, b=0 → q=0x7FFF, dbz=1.
  - Unsigned: a=5, b=0 → q=0xFFFF, dbz=1.
- Overflow, signed F=0: a=-32768, b=-1 → q=0x7FFF, r=0, ovf=1.
- Handshake and reset:
  - a valid held 3 cycles with b not valid → no capture.
  - m_axis_tready held low 5 cycles in OUT → tdata stable, treadys low.
  - areset pulsed at ITER cnt=4 → tvalid and treadys go to 0. A fresh operation then gives the correct result and the aborted one never appears.

Source files
------------

// File: rtl/fixed_div_pkg.sv
// Shared types and helpers for the iterative fixed-point divider.
package fixed_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_OUT
  } state_t;

  // Bit positions inside m_axis_tuser
  localparam int TUSER_DBZ = 0;
  localparam int TUSER_OVF = 1;

  // Quotient width: integer dividend bits plus fractional extension
  function automatic int qw(input int width_a, input int frac_bits);
    return width_a + frac_bits;
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract |b| when it fits.
module fixed_div_step #(
  parameter int WIDTH_B = 8
) (
  input  logic [WIDTH_B:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH_B:0] i_bmag,
  output logic [WIDTH_B:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH_B:0] w_trial;
  logic [WIDTH_B:0] w_diff;

  // The trial value always fits WIDTH_B+1 bits because rem < |b| on entry;
  // the dropped rem MSB still forces a subtract if it were ever set.
  always_comb begin
    w_trial = {i_rem[WIDTH_B-1:0], i_bit};
    w_diff  = w_trial - i_bmag;
    o_qbit  = i_rem[WIDTH_B] | (w_trial >= i_bmag);
    o_rem   = o_qbit ? w_diff : w_trial;
  end

endmodule

// File: rtl/fixed_div_iter.sv
// Iterative restoring fixed-point divider, one quotient bit per clock,
// AXI-Stream operand/result channels with divide-by-zero and overflow flags.
module fixed_div_iter
  import fixed_div_pkg::*;
#(
  parameter int SIGNED    = 1,
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  input  logic [WIDTH_A-1:0]                        s_axis_a_tdata,
  input  logic                                      s_axis_a_tvalid,
  output logic                                      s_axis_a_tready,
  input  logic [WIDTH_B-1:0]                        s_axis_b_tdata,
  input  logic                                      s_axis_b_tvalid,
  output logic                                      s_axis_b_tready,
  output logic [qw(WIDTH_A, FRAC_BITS)+WIDTH_B-1:0] m_axis_tdata,
  output logic [1:0]                                m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready
);

  localparam int QW    = qw(WIDTH_A, FRAC_BITS);
  localparam int OW    = QW + WIDTH_B;
  localparam int CNT_W = $clog2(QW + 1);

  localparam logic [QW-1:0] QMIN = QW'(1) << (QW - 1);
  localparam logic [QW-1:0] QMAX = ~QMIN;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_rdy;
  logic                 r_tvalid;
  logic [OW-1:0]        r_tdata;
  logic [1:0]           r_tuser;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH_A-1:0]   r_a;
  logic [WIDTH_B-1:0]   r_b;
  logic [QW-1:0]        r_shift;
  logic [QW-1:0]        r_quot;
  logic [WIDTH_B:0]     r_rem;
  logic [WIDTH_B:0]     r_bmag;
  logic                 r_qsign;
  logic                 r_rsign;
  logic                 r_dbz;

  logic                 w_capture;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH_A:0]     w_amag;
  logic [WIDTH_B:0]     w_bmag;
  logic [QW-1:0]        w_shift_init;
  logic [WIDTH_B:0]     w_rem_nxt;
  logic                 w_qbit;
  logic                 w_ovf;
  logic [QW-1:0]        w_q_fix;
  logic [WIDTH_B-1:0]   w_r_fix;

  // Magnitude of a WIDTH_A operand, one bit wider so the most negative value is exact
  function automatic logic [WIDTH_A:0] mag_a(input logic [WIDTH_A-1:0] v);
    logic signed [WIDTH_A:0] ext;
    ext = (SIGNED != 0) ? {v[WIDTH_A-1], v} : {1'b0, v};
    return ext[WIDTH_A] ? -ext : ext;
  endfunction

  // Magnitude of a WIDTH_B operand, one bit wider so the most negative value is exact
  function automatic logic [WIDTH_B:0] mag_b(input logic [WIDTH_B-1:0] v);
    logic signed [WIDTH_B:0] ext;
    ext = (SIGNED != 0) ? {v[WIDTH_B-1], v} : {1'b0, v};
    return ext[WIDTH_B] ? -ext : ext;
  endfunction

  // Quotient saturation for divide-by-zero and signed overflow
  function automatic logic [QW-1:0] sat_quot(input logic dbz, input logic ovf,
                                             input logic neg_a, input logic [QW-1:0] q);
    if (dbz) begin
      if (SIGNED == 0) return '1;
      return neg_a ? QMIN : QMAX;
    end
    if (ovf) return QMAX;
    return q;
  endfunction

  // Remainder is forced to zero whenever the quotient saturates
  function automatic logic [WIDTH_B-1:0] sat_rem(input logic dbz, input logic ovf,
                                                 input logic [WIDTH_B-1:0] r);
    return (dbz || ovf) ? '0 : r;
  endfunction

  assign s_axis_a_tready = r_rdy;
  assign s_axis_b_tready = r_rdy;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tdata    = r_tdata;
  assign m_axis_tuser    = r_tuser;

  assign w_capture = (r_state == ST_IDLE) && r_rdy && s_axis_a_tvalid && s_axis_b_tvalid;

  fixed_div_step #(.WIDTH_B(WIDTH_B)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_shift[QW-1]),
    .i_bmag (r_bmag),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Operand preparation and sign-correction/saturation of the finished result
  always_comb begin
    w_sa         = (SIGNED != 0) && r_a[WIDTH_A-1];
    w_sb         = (SIGNED != 0) && r_b[WIDTH_B-1];
    w_amag       = mag_a(r_a);
    w_bmag       = mag_b(r_b);
    w_shift_init = QW'(w_amag) << FRAC_BITS;
    w_ovf        = (SIGNED != 0) && !r_dbz && !r_qsign && (r_quot == QMIN);
    w_q_fix      = sat_quot(r_dbz, w_ovf, r_rsign, r_qsign ? -r_quot : r_quot);
    w_r_fix      = sat_rem(r_dbz, w_ovf,
                           r_rsign ? -r_rem[WIDTH_B-1:0] : r_rem[WIDTH_B-1:0]);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_capture) w_state_nxt = ST_PREP;
      ST_PREP: w_state_nxt = ST_ITER;
      ST_ITER: if (r_cnt == CNT_W'(QW - 1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_OUT;
      ST_OUT:  if (m_axis_tready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered handshake/result outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_rdy    <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy    <= (w_state_nxt == ST_IDLE);
      r_tvalid <= (w_state_nxt == ST_OUT);
      if (r_state == ST_PREP) r_cnt <= '0;
      else if (r_state == ST_ITER) r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_FIX) begin
        r_tdata            <= {w_q_fix, w_r_fix};
        r_tuser[TUSER_DBZ] <= r_dbz;
        r_tuser[TUSER_OVF] <= w_ovf;
      end
    end
  end

  // Datapath registers: operand capture, preparation and restoring iteration
  always_ff @(posedge aclk) begin
    if (w_capture) begin
      r_a <= s_axis_a_tdata;
      r_b <= s_axis_b_tdata;
    end
    if (r_state == ST_PREP) begin
      r_shift <= w_shift_init;
      r_quot  <= '0;
      r_rem   <= '0;
      r_bmag  <= w_bmag;
      r_qsign <= w_sa ^ w_sb;
      r_rsign <= w_sa;
      r_dbz   <= (r_b == '0);
    end else if (r_state == ST_ITER) begin
      r_shift <= r_shift << 1;
      r_quot  <= (r_quot << 1) | QW'(w_qbit);
      r_rem   <= w_rem_nxt;
    end
  end

endmodule

// File: tb/tb_fixed_div_iter.sv
// Directed testbench for fixed_div_iter: signed 16/8, unsigned 16/8 and unsigned 16/8 with 8 fraction bits.
module tb_fixed_div_iter;

  logic clk;
  logic rst;

  // signed, F=0
  logic [15:0] s_a;  logic [7:0] s_b;
  logic s_av, s_bv, s_ar, s_br, s_mv, s_mr;
  logic [23:0] s_md; logic [1:0] s_mu;
  // unsigned, F=0
  logic [15:0] u_a;  logic [7:0] u_b;
  logic u_av, u_bv, u_ar, u_br, u_mv, u_mr;
  logic [23:0] u_md; logic [1:0] u_mu;
  // unsigned, F=8
  logic [15:0] f_a;  logic [7:0] f_b;
  logic f_av, f_bv, f_ar, f_br, f_mv, f_mr;
  logic [31:0] f_md; logic [1:0] f_mu;

  int cur;
  logic        o_tv;
  logic [1:0]  o_rdy;
  logic [31:0] o_data;
  logic [1:0]  o_user;

  int n_cmp = 0;
  int n_err = 0;

  fixed_div_iter #(.SIGNED(1), .WIDTH_A(16), .WIDTH_B(8), .FRAC_BITS(0)) dut_s (
    .aclk(clk), .areset(rst),
    .s_axis_a_tdata(s_a), .s_axis_a_tvalid(s_av), .s_axis_a_tready(s_ar),
    .s_axis_b_tdata(s_b), .s_axis_b_tvalid(s_bv), .s_axis_b_tready(s_br),
    .m_axis_tdata(s_md), .m_axis_tuser(s_mu), .m_axis_tvalid(s_mv), .m_axis_tready(s_mr));

  fixed_div_iter #(.SIGNED(0), .WIDTH_A(16), .WIDTH_B(8), .FRAC_BITS(0)) dut_u (
    .aclk(clk), .areset(rst),
    .s_axis_a_tdata(u_a), .s_axis_a_tvalid(u_av), .s_axis_a_tready(u_ar),
    .s_axis_b_tdata(u_b), .s_axis_b_tvalid(u_bv), .s_axis_b_tready(u_br),
    .m_axis_tdata(u_md), .m_axis_tuser(u_mu), .m_axis_tvalid(u_mv), .m_axis_tready(u_mr));

  fixed_div_iter #(.SIGNED(0), .WIDTH_A(16), .WIDTH_B(8), .FRAC_BITS(8)) dut_f (
    .aclk(clk), .areset(rst),
    .s_axis_a_tdata(f_a), .s_axis_a_tvalid(f_av), .s_axis_a_tready(f_ar),
    .s_axis_b_tdata(f_b), .s_axis_b_tvalid(f_bv), .s_axis_b_tready(f_br),
    .m_axis_tdata(f_md), .m_axis_tuser(f_mu), .m_axis_tvalid(f_mv), .m_axis_tready(f_mr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the instance currently under test
  always_comb begin
    o_tv = 1'b0; o_rdy = 2'b00; o_data = '0; o_user = 2'b00;
    case (cur)
      0: begin o_tv = s_mv; o_rdy = {s_ar, s_br}; o_data = {8'h00, s_md}; o_user = s_mu; end
      1: begin o_tv = u_mv; o_rdy = {u_ar, u_br}; o_data = {8'h00, u_md}; o_user = u_mu; end
      default: begin o_tv = f_mv; o_rdy = {f_ar, f_br}; o_data = f_md; o_user = f_mu; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic [15:0] a, input logic [7:0] b,
                        input logic av, input logic bv);
    case (sel)
      0: begin s_a = a; s_b = b; s_av = av; s_bv = bv; end
      1: begin u_a = a; u_b = b; u_av = av; u_bv = bv; end
      default: begin f_a = a; f_b = b; f_av = av; f_bv = bv; end
    endcase
  endtask

  task automatic set_mr(input int sel, input logic v);
    case (sel)
      0: s_mr = v;
      1: u_mr = v;
      default: f_mr = v;
    endcase
  endtask

  // One complete transaction: capture, latency, result, optional backpressure, handshake
  task automatic run_op(input int sel, input logic [15:0] a, input logic [7:0] b,
                        input logic [31:0] exp_d, input logic [1:0] exp_u,
                        input int exp_lat, input int hold, input string tag);
    int n;
    cur = sel;
    @(negedge clk);
    chk({tag, "_rdy_idle"}, {30'd0, o_rdy}, 32'd3);
    set_in(sel, a, b, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_in(sel, 16'h0, 8'h0, 1'b0, 1'b0);
    n = 0;
    while (!o_tv && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_tdata"}, o_data, exp_d);
    chk({tag, "_tuser"}, {30'd0, o_user}, {30'd0, exp_u});
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_rdy_busy"}, {30'd0, o_rdy}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_held_tdata"}, o_data, exp_d);
      chk({tag, "_held_tvalid"}, {31'd0, o_tv}, 32'd1);
    end
    set_mr(sel, 1'b1);
    @(posedge clk); #1;
    set_mr(sel, 1'b0);
    chk({tag, "_tvalid_drop"}, {31'd0, o_tv}, 32'd0);
    chk({tag, "_rdy_after"}, {30'd0, o_rdy}, 32'd3);
  endtask

  initial begin
    logic seen;
    cur = 0;
    rst = 1'b1;
    set_in(0, 16'h0, 8'h0, 1'b0, 1'b0);
    set_in(1, 16'h0, 8'h0, 1'b0, 1'b0);
    set_in(2, 16'h0, 8'h0, 1'b0, 1'b0);
    s_mr = 1'b0; u_mr = 1'b0; f_mr = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, o_tv}, 32'd0);
    chk("rst_tdata", o_data, 32'd0);
    chk("rst_tuser", {30'd0, o_user}, 32'd0);
    chk("rst_rdy", {30'd0, o_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_first_clk", {30'd0, o_rdy}, 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_first", {30'd0, o_rdy}, 32'd3);

    // main function
    run_op(1, 16'd100, 8'd7, {8'h00, 16'd14, 8'd2}, 2'b00, 18, 0, "u_100_7");
    run_op(0, 16'hFF9C, 8'd7, {8'h00, 16'hFFF2, 8'hFE}, 2'b00, 18, 0, "s_m100_7");
    run_op(0, 16'd100, 8'hF9, {8'h00, 16'hFFF2, 8'h02}, 2'b00, 18, 5, "s_100_m7");
    run_op(2, 16'd1, 8'd3, {24'h000055, 8'h01}, 2'b00, 26, 0, "f_1_3");

    // divide by zero and overflow
    run_op(0, 16'hFFFB, 8'd0, {8'h00, 16'h8000, 8'h00}, 2'b01, 18, 0, "s_dbz_neg");
    run_op(0, 16'd5, 8'd0, {8'h00, 16'h7FFF, 8'h00}, 2'b01, 18, 0, "s_dbz_pos");
    run_op(1, 16'd5, 8'd0, {8'h00, 16'hFFFF, 8'h00}, 2'b01, 18, 0, "u_dbz");
    run_op(0, 16'h8000, 8'hFF, {8'h00, 16'h7FFF, 8'h00}, 2'b10, 18, 0, "s_ovf");

    // a lone valid operand is never captured
    cur = 0;
    @(negedge clk);
    s_a = 16'd9; s_av = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lone_a_rdy", {30'd0, o_rdy}, 32'd3);
    @(negedge clk);
    s_av = 1'b0;
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; seen |= o_tv; end
    chk("lone_a_no_result", {31'd0, seen}, 32'd0);

    // reset in the middle of the iteration
    cur = 0;
    @(negedge clk);
    set_in(0, 16'd200, 8'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_in(0, 16'h0, 8'h0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", {31'd0, o_tv}, 32'd0);
    chk("midrst_rdy", {30'd0, o_rdy}, 32'd0);
    chk("midrst_tdata", o_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; seen |= o_tv; end
    chk("aborted_never_out", {31'd0, seen}, 32'd0);
    run_op(0, 16'd77, 8'd3, {8'h00, 16'd25, 8'd2}, 2'b00, 18, 0, "s_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
